full_beamformer: RTL and testbench

Delay-and-sum receive beamformer core for a 4-channel array. Each channel is a 4-tap FIR filter followed by a 16-deep delay line of filtered samples. A per-channel delay tap is selected, and the aligned channels are summed into one 36-bit result. The block sits below the system controller, which drives the processing phase through `next_control_state` every cycle.

---
 rtl/beamformer_pkg.sv | 24 ++
 rtl/bf_channel.sv | 62 ++++++
 rtl/full_beamformer.sv | 79 +++++++
 tb/tb_full_beamformer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/beamformer_pkg.sv
// Shared phase codes, datapath widths and default FIR coefficients for the
// 4-channel delay-and-sum beamformer.
package beamformer_pkg;

   typedef enum logic [2:0] {
      LOADIN          = 3'd0,
      FILTERING       = 3'd1,
      FINISHFILTERING = 3'd2,
      BEAMFORMING     = 3'd3,
      SUMMING         = 3'd4,
      DONE            = 3'd5
   } phase_t;

   localparam int FILT_W = 34;
   localparam int SUM_W  = 36;

   // h0 is the leftmost field and multiplies the newest sample
   localparam logic [63:0] DEFAULT_COEFS = {16'sd1, 16'sd2, 16'sd2, 16'sd1};

   function automatic logic legal_phase(input logic [2:0] code);
      return code <= 3'd5;
   endfunction

endpackage

// File: rtl/bf_channel.sv
// One beamformer channel: sample history, 4-tap FIR, filtered-sample delay
// line and the aligned-sample register loaded during beamforming.
module bf_channel
   import beamformer_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int COEF_W   = 16,
   parameter int TAPS     = 4,
   parameter int DEPTH    = 16,
   parameter logic [TAPS*COEF_W-1:0] COEFS = DEFAULT_COEFS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  phase_t                      phase,
   input  logic                        sample_valid,
   input  logic signed [SAMPLE_W-1:0]  sample,
   input  logic [$clog2(DEPTH)-1:0]    delay_sel,
   output logic signed [FILT_W-1:0]    aligned
);

   localparam int PROD_W = SAMPLE_W + COEF_W;

   logic signed [SAMPLE_W-1:0] x  [TAPS];
   logic signed [FILT_W-1:0]   fd [DEPTH];
   logic signed [PROD_W-1:0]   prod [TAPS];
   logic signed [FILT_W-1:0]   y;
   logic                       pending;
   logic                       shift_en;

   assign shift_en = sample_valid && (phase == LOADIN || phase == FILTERING);

   always_comb begin
      y = '0;
      for (int k = 0; k < TAPS; k++) begin
         prod[k] = $signed(COEFS[(TAPS-1-k)*COEF_W +: COEF_W]) * x[k];
         y = y + {{(FILT_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
      end
   end

   // y is always taken from the history as it stands after the previous
   // shift, so a push and a new shift can share an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) x[i] <= '0;
         for (int i = 0; i < DEPTH; i++) fd[i] <= '0;
         pending <= 1'b0;
         aligned <= '0;
      end else begin
         if (shift_en) begin
            x[0] <= sample;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
         end
         pending <= sample_valid && (phase == FILTERING);
         if (pending) begin
            fd[0] <= y;
            for (int i = 1; i < DEPTH; i++) fd[i] <= fd[i-1];
         end
         if (phase == BEAMFORMING) aligned <= fd[delay_sel];
      end
   end

endmodule

// File: rtl/full_beamformer.sv
// Delay-and-sum receive beamformer: phase register, per-channel FIR/delay
// slices and the final 36-bit adder tree.
//
// state           | meaning
// LOADIN          | valid samples prime the FIR history only
// FILTERING       | valid samples shift in and push y into the delay line
// FINISHFILTERING | no new samples; an outstanding push drains
// BEAMFORMING     | each channel latches fd[delay_cfg]
// SUMMING         | aligned samples summed into summed_value
// DONE            | everything holds, done asserted
module full_beamformer
   import beamformer_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int SAMPLE_W = 16,
   parameter int COEF_W   = 16,
   parameter int TAPS     = 4,
   parameter int DEPTH    = 16,
   parameter logic [TAPS*COEF_W-1:0] COEFS = DEFAULT_COEFS
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [2:0]                         next_control_state,
   input  logic [NUM_CH*SAMPLE_W-1:0]         sample_in,
   input  logic                               sample_valid,
   input  logic [NUM_CH*$clog2(DEPTH)-1:0]    delay_cfg,
   output logic [2:0]                         control_state,
   output logic signed [SUM_W-1:0]            summed_value,
   output logic                               sum_valid,
   output logic                               done
);

   localparam int DW = $clog2(DEPTH);

   phase_t                   phase;
   logic signed [FILT_W-1:0] aligned [NUM_CH];
   logic signed [SUM_W-1:0]  sum_next;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      bf_channel #(
         .SAMPLE_W (SAMPLE_W),
         .COEF_W   (COEF_W),
         .TAPS     (TAPS),
         .DEPTH    (DEPTH),
         .COEFS    (COEFS)
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .phase        (phase),
         .sample_valid (sample_valid),
         .sample       (sample_in[c*SAMPLE_W +: SAMPLE_W]),
         .delay_sel    (delay_cfg[c*DW +: DW]),
         .aligned      (aligned[c])
      );
   end

   always_comb begin
      sum_next = '0;
      for (int c = 0; c < NUM_CH; c++)
         sum_next = sum_next + {{(SUM_W-FILT_W){aligned[c][FILT_W-1]}}, aligned[c]};
   end

   // Illegal commands (6, 7) leave the phase untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase        <= LOADIN;
         summed_value <= '0;
         sum_valid    <= 1'b0;
      end else begin
         if (legal_phase(next_control_state)) phase <= phase_t'(next_control_state);
         if (phase == SUMMING) summed_value <= sum_next;
         sum_valid <= (phase == SUMMING);
      end
   end

   assign control_state = phase;
   assign done          = (phase == DONE);

endmodule

// File: tb/tb_full_beamformer.sv
// Directed-vector bench for full_beamformer: default coefficients plus two
// full-scale coefficient sets driven with identical stimulus.
module tb_full_beamformer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  next_control_state;
   logic [63:0] sample_in;
   logic        sample_valid;
   logic [15:0] delay_cfg;

   logic [2:0]         cs_def, cs_neg, cs_pos;
   logic signed [35:0] sum_def, sum_neg, sum_pos;
   logic               sv_def, sv_neg, sv_pos;
   logic               done_def, done_neg, done_pos;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   full_beamformer dut (
      .clk(clk), .rst_n(rst_n), .next_control_state(next_control_state),
      .sample_in(sample_in), .sample_valid(sample_valid), .delay_cfg(delay_cfg),
      .control_state(cs_def), .summed_value(sum_def), .sum_valid(sv_def), .done(done_def)
   );

   full_beamformer #(.COEFS({4{-16'sd32768}})) dut_neg (
      .clk(clk), .rst_n(rst_n), .next_control_state(next_control_state),
      .sample_in(sample_in), .sample_valid(sample_valid), .delay_cfg(delay_cfg),
      .control_state(cs_neg), .summed_value(sum_neg), .sum_valid(sv_neg), .done(done_neg)
   );

   full_beamformer #(.COEFS({4{16'sd32767}})) dut_pos (
      .clk(clk), .rst_n(rst_n), .next_control_state(next_control_state),
      .sample_in(sample_in), .sample_valid(sample_valid), .delay_cfg(delay_cfg),
      .control_state(cs_pos), .summed_value(sum_pos), .sum_valid(sv_pos), .done(done_pos)
   );

   function automatic logic [63:0] all4(input logic [15:0] v);
      return {v, v, v, v};
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive inputs just after a rising edge, then sample 1 time unit after the next one.
   task automatic step(input logic [2:0] ns, input logic v, input logic [63:0] s);
      next_control_state = ns;
      sample_valid       = v;
      sample_in          = s;
      @(posedge clk);
      #1;
   endtask

   task automatic run_bf(input logic [15:0] dcfg);
      delay_cfg = dcfg;
      step(3'd3, 1'b0, '0);
      step(3'd3, 1'b0, '0);
      step(3'd4, 1'b0, '0);
      step(3'd4, 1'b0, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      next_control_state = 3'd0;
      sample_in = '0;
      sample_valid = 1'b0;
      delay_cfg = '0;
      #23;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      chk("reset_state", cs_def, 0);
      chk("reset_sum", sum_def, 0);

      // constant input of 100: y = 600 per channel, sum 2400
      for (int i = 0; i < 4; i++) step(3'd0, 1'b1, all4(16'd100));
      step(3'd1, 1'b0, '0);
      step(3'd1, 1'b1, all4(16'd100));
      step(3'd2, 1'b0, '0);
      run_bf(16'h0000);
      chk("const_sum", sum_def, 2400);
      chk("const_sum_valid", sv_def, 1);

      step(3'd5, 1'b0, '0);
      step(3'd5, 1'b0, '0);
      chk("done_flag", done_def, 1);
      chk("done_state", cs_def, 5);
      chk("done_sum_valid_low", sv_def, 0);
      delay_cfg = 16'hFFFF;
      step(3'd5, 1'b1, all4(16'd1234));
      delay_cfg = 16'h5A5A;
      step(3'd5, 1'b0, all4(16'd777));
      step(3'd5, 1'b1, all4(16'hFFFF));
      chk("done_sum_hold", sum_def, 2400);

      // illegal codes while summing
      step(3'd4, 1'b0, '0);
      step(3'd6, 1'b0, '0);
      chk("illegal_6", cs_def, 4);
      step(3'd7, 1'b0, '0);
      chk("illegal_7", cs_def, 4);
      chk("illegal_sum_valid", sv_def, 1);

      // asynchronous reset mid-run, no clock edge
      rst_n = 1'b0;
      #2;
      chk("async_rst_state", cs_def, 0);
      chk("async_rst_sum", sum_def, 0);
      chk("async_rst_sum_valid", sv_def, 0);
      chk("async_rst_done", done_def, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // impulse on ch0 plus 7 zeros: fd0[7..4] = 1,2,2,1
      step(3'd1, 1'b0, '0);
      step(3'd1, 1'b1, 64'h0000_0000_0000_0001);
      for (int i = 0; i < 7; i++) step(3'd1, 1'b1, '0);
      step(3'd2, 1'b0, '0);
      run_bf(16'h3335);
      chk("delay_tap5", sum_def, 2);
      run_bf(16'h0007);
      chk("delay_tap7", sum_def, 1);
      run_bf(16'h0004);
      chk("delay_tap4", sum_def, 1);
      run_bf(16'h0006);
      chk("delay_tap6", sum_def, 2);
      run_bf(16'h000F);
      chk("delay_tap15", sum_def, 0);
      run_bf(16'h0003);
      chk("delay_tap3", sum_def, 0);

      // negative full-scale samples
      do_reset();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) step(3'd0, 1'b1, all4(16'h8000));
      step(3'd1, 1'b1, all4(16'h8000));
      step(3'd2, 1'b1, all4(16'h8000));
      step(3'd2, 1'b1, all4(16'h8000));
      run_bf(16'h0000);
      chk("fs_neg_coefs", sum_neg, 64'sd17179869184);
      chk("fs_pos_coefs", sum_pos, -64'sd17179344896);
      chk("fs_default_coefs", sum_def, -64'sd786432);
      chk("fs_sum_valid", sv_neg, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
